// File: rtl/chess_pkg.sv
// Shared chess encodings for the move collection path: piece codes,
// move/score widths, collector FSM states and the MVV-LVA score function.
package chess_pkg;

    localparam int MOVE_W  = 18;
    localparam int SCORE_W = 6;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } collector_state_e;

    // Move layout: {from[5:0], to[5:0], attacker[2:0], victim[2:0]}.
    // Victim in the high bits makes any capture outrank a quiet move;
    // the cheaper attacker wins among equal victims.
    function automatic logic [SCORE_W-1:0] mvv_lva_score(input logic [MOVE_W-1:0] mv);
        return {mv[2:0], 3'd7 - mv[5:3]};
    endfunction

endpackage

// File: rtl/mvv_lva_select.sv
// Picks the index of the maximum (FIND_MAX=1) or minimum (FIND_MAX=0)
// score among valid entries; the lowest index wins a tie.
module mvv_lva_select
    import chess_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter bit FIND_MAX = 1'b1
) (
    input  logic [DEPTH*SCORE_W-1:0]  scores,
    input  logic [DEPTH-1:0]          valid,
    output logic [$clog2(DEPTH)-1:0]  idx
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [SCORE_W-1:0] best;
    logic               have;
    logic [SCORE_W-1:0] cur;
    logic               better;

    // Linear scan; strict comparison keeps the earliest entry on ties.
    always_comb begin
        idx    = '0;
        best   = '0;
        have   = 1'b0;
        cur    = '0;
        better = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cur    = scores[i*SCORE_W +: SCORE_W];
            better = FIND_MAX ? (cur > best) : (cur < best);
            if (valid[i] && (!have || better)) begin
                idx  = IDX_W'(i);
                best = cur;
                have = 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_collector.sv
// Collects moves from NCOL column producers with a round-robin grant into
// a DEPTH-entry buffer, then drains them best-score-first (MVV-LVA).
// When the buffer is full a better move evicts the current worst one.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. mv_ready is one-hot and depends only on mv_valid and
// registered state; out_data is held stable while out_valid=1 and
// out_ready=0.
module move_collector
    import chess_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NCOL  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NCOL-1:0]             mv_valid,
    input  logic [MOVE_W*NCOL-1:0]      mv_data,
    output logic [NCOL-1:0]             mv_ready,
    input  logic [NCOL-1:0]             col_done,
    output logic                        out_valid,
    output logic [MOVE_W-1:0]           out_data,
    output logic [SCORE_W-1:0]          out_score,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [1:0]                  dbg_state,
    output logic [$clog2(DEPTH):0]      dbg_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int PTR_W = (NCOL > 1) ? $clog2(NCOL) : 1;

    collector_state_e state, state_next;

    logic [CNT_W-1:0]         count;
    logic [DEPTH-1:0]         valid;
    logic [PTR_W-1:0]         ptr;
    logic [NCOL-1:0]          mask;
    logic [MOVE_W-1:0]        mem [DEPTH];
    logic [DEPTH*SCORE_W-1:0] scores;

    logic                     grant_found;
    logic [PTR_W-1:0]         grant_idx;
    logic [PTR_W:0]           cand;
    logic                     grant_en;
    logic [PTR_W-1:0]         ptr_next;
    logic [MOVE_W-1:0]        in_move;
    logic [SCORE_W-1:0]       in_score;
    logic                     full;
    logic [IDX_W-1:0]         free_idx;
    logic [IDX_W-1:0]         max_idx;
    logic [IDX_W-1:0]         min_idx;
    logic [SCORE_W-1:0]       min_score;
    logic                     replace;
    logic                     write_en;
    logic [IDX_W-1:0]         wr_idx;
    logic                     pop;

    assign dbg_state = state;
    assign dbg_count = count;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state; start overrides everything.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    state_next = ST_IDLE;
            ST_COLLECT: if ((&mask) && (mv_valid == '0)) state_next = ST_DRAIN;
            ST_DRAIN:   if (count == '0) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (start) state_next = ST_COLLECT;
    end

    // Round-robin search: first valid column at or after ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NCOL; i++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NCOL)) cand = cand - (PTR_W+1)'(NCOL);
            if (!grant_found && mv_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Lowest free buffer slot.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IDX_W'(i);
        end
    end

    mvv_lva_select #(.DEPTH(DEPTH), .FIND_MAX(1'b1)) u_max_sel (
        .scores (scores),
        .valid  (valid),
        .idx    (max_idx)
    );

    mvv_lva_select #(.DEPTH(DEPTH), .FIND_MAX(1'b0)) u_min_sel (
        .scores (scores),
        .valid  (valid),
        .idx    (min_idx)
    );

    assign grant_en  = (state == ST_COLLECT) && grant_found && !start;
    assign ptr_next  = (grant_idx == PTR_W'(NCOL - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign in_move   = mv_data[int'(grant_idx)*MOVE_W +: MOVE_W];
    assign in_score  = mvv_lva_score(in_move);
    assign full      = (count == CNT_W'(DEPTH));
    assign min_score = scores[int'(min_idx)*SCORE_W +: SCORE_W];
    assign replace   = grant_en && full && (in_score > min_score);
    assign write_en  = (grant_en && !full) || replace;
    assign wr_idx    = full ? min_idx : free_idx;
    assign pop       = (state == ST_DRAIN) && (count != '0) && out_ready && !start;

    // Handshake and status outputs.
    always_comb begin
        mv_ready  = '0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        if (grant_en) mv_ready[grant_idx] = 1'b1;
        if (state == ST_DRAIN) begin
            out_valid = (count != '0);
            done      = (count == '0) && !start;
        end
    end

    assign out_data  = mem[max_idx];
    assign out_score = scores[int'(max_idx)*SCORE_W +: SCORE_W];

    // Control registers: occupancy, pointer, done mask, overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            valid    <= '0;
            ptr      <= '0;
            mask     <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            count    <= '0;
            valid    <= '0;
            ptr      <= '0;
            mask     <= '0;
            overflow <= 1'b0;
        end else begin
            if (state == ST_COLLECT) mask <= mask | col_done;
            if (grant_en) begin
                ptr <= ptr_next;
                if (!full) begin
                    valid[free_idx] <= 1'b1;
                    count           <= count + CNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (pop) begin
                valid[max_idx] <= 1'b0;
                count          <= count - CNT_W'(1);
            end
        end
    end

    // Move and score storage; contents only matter where valid is set.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_idx]                            <= in_move;
            scores[int'(wr_idx)*SCORE_W +: SCORE_W] <= in_score;
        end
    end

endmodule

// File: tb/tb_move_collector.sv
module tb_move_collector;

    localparam int DEPTH = 16;
    localparam int NCOL  = 8;
    localparam int MAXM  = 32;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic [NCOL-1:0]   mv_valid = '0;
    logic [18*NCOL-1:0] mv_data = '0;
    logic [NCOL-1:0]   mv_ready;
    logic [NCOL-1:0]   col_done = '0;
    logic              out_valid;
    logic [17:0]       out_data;
    logic [5:0]        out_score;
    logic              out_ready = 1'b0;
    logic              busy, done, overflow;
    logic [1:0]        dbg_state;
    logic [4:0]        dbg_count;

    move_collector #(.DEPTH(DEPTH), .NCOL(NCOL)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mv_valid(mv_valid), .mv_data(mv_data), .mv_ready(mv_ready),
        .col_done(col_done), .out_valid(out_valid), .out_data(out_data),
        .out_score(out_score), .out_ready(out_ready), .busy(busy),
        .done(done), .overflow(overflow), .dbg_state(dbg_state),
        .dbg_count(dbg_count)
    );

    int checks = 0;
    int errors = 0;

    // per-column stimulus
    logic [17:0] col_mem [NCOL][MAXM];
    int          col_n   [NCOL];
    int          col_rd  [NCOL];

    // reference model: slot buffer following the buffering rules
    logic [17:0] m_mem   [DEPTH];
    bit          m_valid [DEPTH];
    int          m_cnt;
    bit          m_ovf;
    int          m_ptr;

    // scoreboard: expected drain order {score, move}
    logic [23:0] exp_q[$];
    logic [5:0]  obs_q[$];

    function automatic int score_of(input logic [17:0] m);
        int att, vic;
        att = int'(m[5:3]);
        vic = int'(m[2:0]);
        return vic * 8 + (7 - att);
    endfunction

    function automatic logic [17:0] mk_move(input int from, input int to, input int att, input int vic);
        logic [5:0] f, t;
        logic [2:0] a, v;
        f = 6'(from); t = 6'(to); a = 3'(att); v = 3'(vic);
        return {f, t, a, v};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        m_cnt = 0; m_ovf = 0; m_ptr = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic model_insert(input logic [17:0] m);
        int slot, mn;
        if (m_cnt < DEPTH) begin
            slot = -1;
            for (int i = 0; i < DEPTH; i++) if (slot < 0 && !m_valid[i]) slot = i;
            m_mem[slot] = m; m_valid[slot] = 1; m_cnt++;
        end else begin
            m_ovf = 1;
            mn = 0;
            for (int i = 1; i < DEPTH; i++) if (score_of(m_mem[i]) < score_of(m_mem[mn])) mn = i;
            if (score_of(m) > score_of(m_mem[mn])) m_mem[mn] = m;
        end
    endtask

    // expected drain order: repeated best-score extraction, earliest slot on ties
    task automatic build_exp();
        bit v [DEPTH];
        int best;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) v[i] = m_valid[i];
        for (int n = 0; n < m_cnt; n++) begin
            best = -1;
            for (int i = 0; i < DEPTH; i++)
                if (v[i] && (best < 0 || score_of(m_mem[i]) > score_of(m_mem[best]))) best = i;
            exp_q.push_back({6'(score_of(m_mem[best])), m_mem[best]});
            v[best] = 0;
        end
    endtask

    task automatic clear_cols();
        for (int c = 0; c < NCOL; c++) begin col_n[c] = 0; col_rd[c] = 0; end
    endtask

    task automatic add_move(input int c, input logic [17:0] m);
        col_mem[c][col_n[c]] = m;
        col_n[c]++;
    endtask

    // driver: start pulse, then the DUT sits in COLLECT
    task automatic start_pass();
        @(negedge clk);
        start = 1'b1; mv_valid = '0; col_done = '0; out_ready = 1'b0;
        #1;
        checks++;
        if (mv_ready !== '0) begin errors++; $display("FAIL start_ready got=%b exp=0", mv_ready); end
        @(negedge clk);
        start = 1'b0;
        model_clear();
    endtask

    // driver: feed columns until the DUT enters DRAIN, checking every grant
    task automatic run_pass(input int avail_pct);
        int grant, c;
        bit pending, any_pending;
        logic [NCOL-1:0] exp_rdy;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            any_pending = 0;
            for (int k = 0; k < NCOL; k++) begin
                pending = col_rd[k] < col_n[k];
                any_pending |= pending;
                mv_valid[k] = pending && ($urandom_range(99, 0) < avail_pct);
                mv_data[k*18 +: 18] = pending ? col_mem[k][col_rd[k]] : 18'h0;
                col_done[k] = !pending;
            end
            #1;
            if (dbg_state == S_DRAIN) begin
                checks++;
                if (mv_ready !== '0 || any_pending) begin
                    errors++;
                    $display("FAIL drain_entry ready=%b pending=%0d exp ready=0 pending=0", mv_ready, any_pending);
                end
                mv_valid = '0; col_done = '0;
                build_exp();
                return;
            end
            grant = -1;
            for (int i = 0; i < NCOL; i++) begin
                c = (m_ptr + i) % NCOL;
                if (grant < 0 && mv_valid[c]) grant = c;
            end
            exp_rdy = (grant >= 0) ? NCOL'(1 << grant) : '0;
            checks++;
            if (mv_ready !== exp_rdy || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL grant got ready=%b ov=%b exp ready=%b ov=0", mv_ready, out_valid, exp_rdy);
            end
            if (grant >= 0) begin
                model_insert(col_mem[grant][col_rd[grant]]);
                col_rd[grant]++;
                m_ptr = (grant + 1) % NCOL;
            end
        end
        errors++;
        $display("FAIL collect_timeout state=%0d exp=%0d", dbg_state, S_DRAIN);
        mv_valid = '0; col_done = '0;
    endtask

    // driver + scoreboard: drain with random out_ready, compare to exp_q
    task automatic drain_pass(input int ready_pct);
        for (int k = 0; k < 600; k++) begin
            if (k > 0) @(negedge clk);
            out_ready = ($urandom_range(99, 0) < ready_pct);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                if (done !== 1'b1 || out_valid !== 1'b0 || overflow !== m_ovf) begin
                    errors++;
                    $display("FAIL drain_end done=%b ov=%b ovf=%b exp done=1 ov=0 ovf=%b", done, out_valid, overflow, m_ovf);
                end
                out_ready = 1'b0;
                @(negedge clk); #1;
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL after_done busy=%b done=%b exp 0 0", busy, done);
                end
                return;
            end
            checks++;
            if (out_valid !== 1'b1 || done !== 1'b0 || {out_score, out_data} !== exp_q[0]) begin
                errors++;
                $display("FAIL drain_data ov=%b done=%b got=%h exp ov=1 done=0 data=%h", out_valid, done, {out_score, out_data}, exp_q[0]);
            end
            if (out_ready) begin
                obs_q.push_back(out_score);
                void'(exp_q.pop_front());
            end
        end
        errors++;
        $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        mv_valid = '1; col_done = '1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (dbg_state !== S_IDLE || dbg_count !== 0 || out_valid !== 0 || mv_ready !== 0 ||
            busy !== 0 || done !== 0 || overflow !== 0) begin
            errors++;
            $display("FAIL reset st=%0d cnt=%0d ov=%b rdy=%b busy=%b done=%b ovf=%b exp all 0",
                     dbg_state, dbg_count, out_valid, mv_ready, busy, done, overflow);
        end
        @(negedge clk);
        reset = 1'b1; mv_valid = '0; col_done = '0; out_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 0 || mv_ready !== 0) begin
            errors++; $display("FAIL idle_ignore busy=%b rdy=%b exp 0 0", busy, mv_ready);
        end
    endtask

    task automatic test_round_robin();
        start_pass();
        clear_cols();
        add_move(0, mk_move(8, 16, 1, 0));
        add_move(3, mk_move(9, 17, 2, 0));
        add_move(7, mk_move(10, 18, 3, 1));
        add_move(0, mk_move(11, 19, 4, 2));
        run_pass(100);
        checks++;
        if (m_ptr !== 1 || exp_q.size() !== 4) begin
            errors++; $display("FAIL rr_model ptr=%0d n=%0d exp ptr=1 n=4", m_ptr, exp_q.size());
        end
        drain_pass(100);
    endtask

    task automatic test_ordering();
        start_pass();
        clear_cols();
        add_move(0, mk_move(3, 12, 5, 1));  // QxP
        add_move(1, mk_move(8, 59, 1, 5));  // PxQ
        add_move(2, mk_move(1, 18, 2, 0));  // quiet knight
        run_pass(100);
        drain_pass(100);
        checks++;
        if (obs_q.size() !== 3 || obs_q[0] !== 6'd46 || obs_q[1] !== 6'd10 || obs_q[2] !== 6'd5) begin
            errors++;
            $display("FAIL ordering n=%0d s0=%0d s1=%0d s2=%0d exp 3 46 10 5", obs_q.size(),
                     obs_q.size() > 0 ? obs_q[0] : 0, obs_q.size() > 1 ? obs_q[1] : 0, obs_q.size() > 2 ? obs_q[2] : 0);
        end
    endtask

    task automatic test_overflow();
        start_pass();
        clear_cols();
        for (int i = 0; i < 17; i++) add_move(i % NCOL, mk_move(i, i + 8, 1, 1));
        add_move(1, mk_move(0, 59, 4, 5));  // RxQ arrives after the 17 PxP
        run_pass(100);
        drain_pass(100);
        checks++;
        if (obs_q.size() !== 16 || obs_q[0] !== 6'd43 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow pops=%0d first=%0d ovf=%b exp 16 43 1", obs_q.size(),
                     obs_q.size() > 0 ? obs_q[0] : 0, overflow);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] first;
        start_pass();
        clear_cols();
        add_move(2, mk_move(5, 6, 3, 2));
        add_move(4, mk_move(7, 8, 6, 4));
        add_move(6, mk_move(9, 10, 1, 3));
        run_pass(100);
        first = exp_q[0];
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            out_ready = 1'b0;
            #1;
            checks++;
            if ({out_score, out_data} !== first || dbg_count !== 5'd3 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure data=%h cnt=%0d ov=%b exp %h 3 1", {out_score, out_data}, dbg_count, out_valid, first);
            end
        end
        drain_pass(100);
    endtask

    task automatic test_empty_pass();
        start_pass();
        clear_cols();
        run_pass(100);
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL empty_pass ov=%b done=%b exp 0 1", out_valid, done);
        end
        drain_pass(100);
    endtask

    task automatic test_start_priority();
        start_pass();
        clear_cols();
        add_move(2, mk_move(4, 5, 2, 3));
        @(negedge clk);
        mv_valid = 8'b0000_0100; mv_data[2*18 +: 18] = col_mem[2][0]; start = 1'b1;
        #1;
        checks++;
        if (mv_ready !== '0) begin errors++; $display("FAIL start_priority rdy=%b exp 0", mv_ready); end
        @(negedge clk);
        start = 1'b0; mv_valid = '0;
        #1;
        checks++;
        if (dbg_count !== 0 || dbg_state !== S_COLLECT) begin
            errors++; $display("FAIL start_restart cnt=%0d st=%0d exp 0 %0d", dbg_count, dbg_state, S_COLLECT);
        end
        model_clear();
        run_pass(100);
        drain_pass(100);
    endtask

    task automatic test_reset_mid_drain();
        start_pass();
        clear_cols();
        for (int i = 0; i < 4; i++) add_move(i * 2, mk_move(i, 63 - i, 2, i + 1));
        run_pass(100);
        checks++;
        if (dbg_count !== 5'd4 || out_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset cnt=%0d ov=%b exp 4 1", dbg_count, out_valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dbg_state !== S_IDLE || out_valid !== 0 || dbg_count !== 0 || done !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL mid_reset st=%0d ov=%b cnt=%0d done=%b busy=%b exp 0 0 0 0 0", dbg_state, out_valid, dbg_count, done, busy);
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 0 || done !== 0) begin
            errors++; $display("FAIL reset_hold ov=%b done=%b exp 0 0", out_valid, done);
        end
        out_ready = 1'b0;
        reset = 1'b1;
        start_pass();
        #1;
        checks++;
        if (dbg_count !== 0 || out_valid !== 0) begin
            errors++; $display("FAIL restart_count cnt=%0d ov=%b exp 0 0", dbg_count, out_valid);
        end
        clear_cols();
        run_pass(100);
        drain_pass(100);
    endtask

    task automatic test_random();
        int n, c;
        for (int p = 0; p < 8; p++) begin
            start_pass();
            clear_cols();
            n = $urandom_range(24, 0);
            for (int i = 0; i < n; i++) begin
                c = $urandom_range(NCOL - 1, 0);
                add_move(c, mk_move($urandom_range(63, 0), $urandom_range(63, 0),
                                    $urandom_range(6, 1), $urandom_range(5, 0)));
            end
            run_pass(70);
            drain_pass(60);
        end
    endtask

    initial begin
        clear_cols();
        model_clear();
        test_reset();
        test_round_robin();
        test_ordering();
        test_overflow();
        test_backpressure();
        test_empty_pass();
        test_start_priority();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_collector.md
MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 16, the number of move buffer entries (power of two, at least 2).
REQ-002 SHALL have parameter NCOL, default 8, the number of column producers.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins a new collection pass.
REQ-006 SHALL have port mv_valid, input, NCOL bits: column c is offering a move.
REQ-007 SHALL have port mv_data, input, 18*NCOL bits: column c occupies [18c+17:18c] as {from[5:0], to[5:0], attacker[2:0], victim[2:0]}.
REQ-008 SHALL have port mv_ready, output, NCOL bits: column c's move is accepted this cycle.
REQ-009 SHALL have port col_done, input, NCOL bits: column c has no further moves this pass.
REQ-010 SHALL have port out_valid, output, 1 bit: the best buffered move is presented.
REQ-011 SHALL have port out_data, output, 18 bits: that move.
REQ-012 SHALL have port out_score, output, 6 bits: that move's score.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer takes out_data.
REQ-014 SHALL have port busy, output, 1 bit: the FSM is not IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when the pass is fully drained.
REQ-016 SHALL have port overflow, output, 1 bit: sticky; the buffer was full when a move arrived during this pass.

Function
REQ-017 SHALL encode pieces as EMPTY=0, PAWN=1, KNIGHT=2, BISHOP=3, ROOK=4, QUEEN=5, KING=6.
REQ-018 SHALL compute score as {victim, 3'd7-attacker}, 6 bits unsigned; a quiet move (victim EMPTY) scores below every capture.
REQ-019 SHALL implement FSM states IDLE, COLLECT and DRAIN.
REQ-020 SHALL, on start in any state, clear count, valid bits, the done mask, overflow and the round-robin pointer (pointer to 0), then enter COLLECT the next cycle.
REQ-021 SHALL, in COLLECT, grant one column per cycle: the lowest index at or after the pointer with mv_valid set, wrapping modulo NCOL.
REQ-022 SHALL assert mv_ready one-hot for the granted column only, combinationally from mv_valid and registered state.
REQ-023 SHALL, after each grant, set the pointer to grant+1 mod NCOL.
REQ-024 SHALL hold mv_ready all zero in IDLE and DRAIN.
REQ-025 SHALL write an accepted move into the free entry with the lowest index when count<DEPTH, with count incremented the next cycle.
REQ-026 SHALL, when count==DEPTH, still accept the move: it replaces the minimum-score entry (lowest index on tie) only if its score is strictly greater, otherwise it is discarded; overflow is set in both cases.
REQ-027 SHALL OR col_done into a latched done mask each cycle while in COLLECT.
REQ-028 SHALL go from COLLECT to DRAIN when the mask is all ones and mv_valid is all zero in the same cycle.
REQ-029 SHALL, in DRAIN, hold out_valid=1 while count>0.
REQ-030 SHALL, in DRAIN, drive out_data and out_score from the maximum-score valid entry (lowest index on tie).
REQ-031 SHALL treat out_valid & out_ready as a pop: the entry is invalidated and count decremented the next cycle.
REQ-032 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-033 SHALL, in DRAIN with count==0, pulse done for 1 cycle and enter IDLE; an empty pass drains in 1 cycle.
REQ-034 SHALL ignore mv_valid and col_done outside COLLECT.
REQ-035 SHALL hold out_valid=0 outside DRAIN.
REQ-036 SHALL give start priority over every other event in the same cycle.

Reset
REQ-037 SHALL, while reset=0, asynchronously force state IDLE, count 0, all valid bits 0, pointer 0, done mask 0, overflow 0, done 0, out_valid 0 and mv_ready 0.
REQ-038 SHALL, when reset is asserted mid-pass, discard all buffered moves; no pop or done follows.

Structure
REQ-039 SHALL take piece codes, MOVE_W=18 and SCORE_W=6 from the shared chess_pkg package.
REQ-040 SHALL place max/min score index selection in one sub-module, mvv_lva_select, instantiated twice (max for drain, min for replacement).

Verification
REQ-041 SHALL cover round-robin: after start, columns 0, 3 and 7 hold mv_valid -> grants in order 0, 3, 7, one per cycle, with the pointer wrapping.
REQ-042 SHALL cover ordering: moves QxP {5,1}, PxQ {1,5} and a quiet N move are collected -> drained as PxQ (score 46), QxP (10), quiet (5).
REQ-043 SHALL cover overflow: 17 pawn-takes-pawn moves, then 1 RxQ -> 16 pops, RxQ first with score 43, overflow=1.
REQ-044 SHALL cover backpressure: out_ready held 0 for 5 cycles in DRAIN -> out_data stable and count unchanged.
REQ-045 SHALL cover an empty pass: start with all col_done=1 and no moves -> done pulses without out_valid ever asserting.
REQ-046 SHALL cover reset mid-DRAIN with count=4 -> IDLE, out_valid=0, and count=0 on the next start.
